// File: rtl/proc_instr_sequencer.sv
// -----------------------------------------------------------------------------
// proc_instr_sequencer
//
// Instruction feeder for a multi-cycle processor. A small program memory is
// loaded over a write port while the sequencer is not busy. On Start the
// sequencer walks the program from address 0:
//
//   - It drives DIN with the current word and pulses Run for one cycle.
//   - It waits for the processor's Done.
//   - It then issues the next word.
//
// The two-word instruction mvi (opcode = word[8:6] == MVI_OP) has its
// immediate word placed on DIN in the cycle that follows Run.
//
// Handshake: Run is a one-cycle strobe that qualifies DIN. The processor
// answers with Done, and the sequencer accepts Done only in WAIT or IMM.
// Done arriving in any other state has no effect. The next Run comes in the
// cycle after the accepted Done, unless the sequencer halts instead.
//
// Optional feature (macro SEQ_TIMEOUT_EN):
//   This adds a Done watchdog. If Done is missing for TIMEOUT cycles, the
//   sequencer moves to an ERR state that raises Error. Only Start or Reset
//   leave ERR. When the macro is undefined there is no ERR state, and
//   Error is tied to 0.
//
// Parameters:
//   DATA_W   DIN / program word width (must be >= 9 for the opcode field)
//   ADDR_W   program address width, memory depth = 2**ADDR_W
//   MVI_OP   opcode value (word[8:6]) of the two-word instruction mvi
//   TIMEOUT  Done watchdog limit in cycles (SEQ_TIMEOUT_EN only)
//
// Ports:
//   i_clock      clock, rising edge
//   i_reset      synchronous active-high reset
//   i_prog_we    program write strobe (dropped while o_busy=1)
//   i_prog_addr  program write address
//   i_prog_data  program write data
//   i_prog_len   number of valid program words, sampled on i_start
//   i_start      start at PC=0 (accepted in IDLE/HALT/ERR)
//   i_stop       halt request, latched, acted on at the next Done
//   i_done       processor instruction-complete
//   o_din        word presented to the processor
//   o_run        one-cycle issue pulse
//   o_pc         address of the current/next instruction
//   o_busy       1 in ISSUE/WAIT/IMM
//   o_halted     1 in HALT
//   o_error      1 in ERR (0 when SEQ_TIMEOUT_EN is undefined)
//   o_dbg_state  current FSM state encoding
// -----------------------------------------------------------------------------
module proc_instr_sequencer #(
   parameter int         DATA_W  = 16,
   parameter int         ADDR_W  = 4,
   parameter logic [2:0] MVI_OP  = 3'b001,
   parameter int         TIMEOUT = 255
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_prog_we,
   input  logic [ADDR_W-1:0] i_prog_addr,
   input  logic [DATA_W-1:0] i_prog_data,
   input  logic [ADDR_W:0]   i_prog_len,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic              i_done,
   output logic [DATA_W-1:0] o_din,
   output logic              o_run,
   output logic [ADDR_W:0]   o_pc,
   output logic              o_busy,
   output logic              o_halted,
   output logic              o_error,
   output logic [2:0]        o_dbg_state
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_IMM   = 3'd3,
      S_HALT  = 3'd4
`ifdef SEQ_TIMEOUT_EN
      ,
      S_ERR   = 3'd5
`endif
   } state_t;

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   state_t            r_state;
   logic [ADDR_W:0]   r_pc;
   logic [ADDR_W:0]   r_len;
   logic              r_stop;
   logic [DATA_W-1:0] r_mem [DEPTH];

   // ---------------------------------------------------------------------------
   // Next-state values and helper wires
   // ---------------------------------------------------------------------------
   state_t            w_state_nxt;
   logic [ADDR_W:0]   w_pc_nxt;
   logic [ADDR_W:0]   w_len_nxt;
   logic              w_stop_nxt;

   logic              w_busy;
   logic              w_can_start;
   logic [ADDR_W-1:0] w_addr;
   logic [ADDR_W-1:0] w_addr_p1;
   logic [DATA_W-1:0] w_cur_word;
   logic [DATA_W-1:0] w_imm_word;
   logic [2:0]        w_opcode;
   logic [ADDR_W+1:0] w_pc_inc;
   logic              w_end;

   // Memory is addressed modulo its depth. PC itself keeps the extra bit,
   // so a program length of exactly 2**ADDR_W, or more, can still be
   // compared against PC.
   assign w_addr     = r_pc[ADDR_W-1:0];
   assign w_addr_p1  = w_addr + ADDR_W'(1);
   assign w_cur_word = r_mem[w_addr];
   assign w_imm_word = r_mem[w_addr_p1];
   assign w_opcode   = w_cur_word[8:6];

   assign w_busy = (r_state == S_ISSUE) || (r_state == S_WAIT) ||
                   (r_state == S_IMM);

`ifdef SEQ_TIMEOUT_EN
   assign w_can_start = (r_state == S_IDLE) || (r_state == S_HALT) ||
                        (r_state == S_ERR);
`else
   assign w_can_start = (r_state == S_IDLE) || (r_state == S_HALT);
`endif

   // The PC advance is one extra bit wide, so that PC+2 near the top of
   // the range cannot wrap below len and keep the program running.
   assign w_pc_inc = {1'b0, r_pc} +
                     ((r_state == S_IMM) ? (ADDR_W+2)'(2) : (ADDR_W+2)'(1));
   assign w_end    = (w_pc_inc >= {1'b0, r_len});

`ifdef SEQ_TIMEOUT_EN
   localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] r_wdog;
   logic            w_wdog_expired;

   // At the last waiting cycle the counter holds TIMEOUT-1. The clock
   // edge that would bring it to TIMEOUT is the edge that enters ERR.
   assign w_wdog_expired = (r_wdog == WD_W'(TIMEOUT - 1));

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_wdog <= '0;
      end else if (w_state_nxt == S_ISSUE) begin
         r_wdog <= '0;
      end else if ((r_state == S_WAIT) || (r_state == S_IMM)) begin
         r_wdog <= r_wdog + WD_W'(1);
      end
   end
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT != 0);
`endif

   // ---------------------------------------------------------------------------
   // Program memory
   // No reset: the contents survive Reset. Writes are refused while an
   // instruction is in flight, and also during Reset, which overrides
   // every other input.
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clock) begin
      if (i_prog_we && !w_busy && !i_reset) begin
         r_mem[i_prog_addr] <= i_prog_data;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM process 1: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_pc    <= '0;
         r_len   <= '0;
         r_stop  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_len   <= w_len_nxt;
         r_stop  <= w_stop_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM process 2: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_len_nxt   = r_len;
      w_stop_nxt  = r_stop;

      if (w_can_start) begin
         // IDLE / HALT / ERR: Start relaunches, and a lone Stop only
         // clears the latch.
         if (i_start) begin
            w_pc_nxt    = '0;
            w_len_nxt   = i_prog_len;
            w_stop_nxt  = 1'b0;
            w_state_nxt = (i_prog_len == '0) ? S_HALT : S_ISSUE;
         end else if (i_stop) begin
            w_stop_nxt = 1'b0;
         end
      end else begin
         case (r_state)
            S_ISSUE: begin
               // Done in the issue cycle belongs to no instruction of
               // ours, so it is ignored.
               if (i_stop) begin
                  w_stop_nxt = 1'b1;
               end
               w_state_nxt = (w_opcode == MVI_OP) ? S_IMM : S_WAIT;
            end

            S_WAIT, S_IMM: begin
               if (i_stop) begin
                  w_stop_nxt = 1'b1;
               end
               if (i_done) begin
                  w_pc_nxt = w_pc_inc[ADDR_W:0];
                  // A Stop that arrives in the same cycle as Done still
                  // counts at this boundary.
                  if (w_end || r_stop || i_stop) begin
                     w_state_nxt = S_HALT;
                  end else begin
                     w_state_nxt = S_ISSUE;
                  end
               end
`ifdef SEQ_TIMEOUT_EN
               else if (w_wdog_expired) begin
                  w_state_nxt = S_ERR;
               end
`endif
            end

            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // FSM process 3: outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      o_din    = '0;
      o_run    = 1'b0;
      o_busy   = 1'b0;
      o_halted = 1'b0;
      o_error  = 1'b0;

      case (r_state)
         S_ISSUE: begin
            o_din  = w_cur_word;
            o_run  = 1'b1;
            o_busy = 1'b1;
         end
         S_WAIT: begin
            o_din  = w_cur_word;
            o_busy = 1'b1;
         end
         S_IMM: begin
            // The immediate is the following word, and it wraps to
            // mem[0] at the top address.
            o_din  = w_imm_word;
            o_busy = 1'b1;
         end
         S_HALT: begin
            o_halted = 1'b1;
         end
`ifdef SEQ_TIMEOUT_EN
         S_ERR: begin
            o_error = 1'b1;
         end
`endif
         default: begin
            o_din = '0;
         end
      endcase
   end

   assign o_pc        = r_pc;
   assign o_dbg_state = r_state;

endmodule
